// File: rtl/axi_master_bridge_pkg.sv
// axi_master_bridge_pkg: shared AXI codes, size codes, FSM states and byte-lane mask helper for the bridge
package axi_master_bridge_pkg;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;
  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B} state_t;
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    return size == SIZE_B ? 8'h01 : size == SIZE_H ? 8'h03 : size == SIZE_W ? 8'h0F : 8'hFF;
  endfunction
endpackage

// File: rtl/axi_master_bridge_lane_align.sv
// axi_master_bridge_lane_align: maps access size and byte offset onto the 8 AXI byte lanes
//  size/offset   access size code and addr[2:0]
//  wdata_in      LSB-aligned store data  -> wdata_out shifted into its lanes, wstrb lane enables
//  rdata_in      raw AXI read beat       -> rdata_out shifted down to LSB, bytes above size zeroed
module axi_master_bridge_lane_align
  import axi_master_bridge_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]        size,
  input  logic [2:0]        offset,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] rdata_in,
  output logic [7:0]        wstrb,
  output logic [DATA_W-1:0] wdata_out,
  output logic [DATA_W-1:0] rdata_out
);
  logic [7:0] m;
  logic [DATA_W-1:0] byte_mask;
  assign m = size_mask(size);
  for (genvar i = 0; i < 8; i++) assign byte_mask[i*8 +: 8] = {8{m[i]}};
  // lanes pushed past byte 7 fall off the 8-bit strobe
  assign wstrb = m << offset;
  assign wdata_out = wdata_in << {offset, 3'b000};
  assign rdata_out = (rdata_in >> {offset, 3'b000}) & byte_mask;
endmodule

// File: rtl/axi_master_bridge.sv
// axi_master_bridge: runs one arbiter request at a time as a single-beat AXI4 read or write
//  clock/reset   single clock, asynchronous active-high reset
//  req_*         request from arbiter; req_ready high only while idle
//  rsp_*         one-cycle completion pulse with id, LSB-aligned read data and error flag
//  aw/w/b/ar/r   AXI4 master channels, len=0, INCR bursts
//  AXI_BRIDGE_RESP_CHECK_EN: when defined rsp_err reports non-OKAY rresp/bresp, otherwise rsp_err stays 0
module axi_master_bridge
  import axi_master_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic [ID_W-1:0]   req_id,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [ID_W-1:0]   awid,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [7:0]        wstrb,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  input  logic [ID_W-1:0]   bid,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [ID_W-1:0]   arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [ID_W-1:0]   rid
);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rd_aligned;
  logic [1:0] size_q;
  logic [ID_W-1:0] id_q;
  logic aw_done, w_done, rd_fin, wr_fin, r_err, b_err, unused_bits;
`ifdef AXI_BRIDGE_RESP_CHECK_EN
  assign r_err = rresp != AXI_RESP_OKAY;
  assign b_err = bresp != AXI_RESP_OKAY;
  assign unused_bits = ^{rid, rlast, bid};
`else
  assign r_err = 1'b0;
  assign b_err = 1'b0;
  assign unused_bits = ^{rid, rlast, bid, rresp, bresp};
`endif
  axi_master_bridge_lane_align #(.DATA_W(DATA_W)) u_align (
    .size(size_q),
    .offset(addr_q[2:0]),
    .wdata_in(wdata_q),
    .rdata_in(rdata),
    .wstrb(wstrb),
    .wdata_out(wdata),
    .rdata_out(rd_aligned)
  );
  // req_ready is held low while reset is asserted so nothing is accepted during reset
  assign req_ready = state == IDLE && !reset;
  assign arvalid = state == RD_A;
  assign araddr = addr_q;
  assign arid = id_q;
  assign arlen = 8'd0;
  assign arsize = {1'b0, size_q};
  assign arburst = AXI_BURST_INCR;
  assign rready = state == RD_D;
  // AW and W are offered together and each retires on its own handshake
  assign awvalid = state == WR_AW && !aw_done;
  assign wvalid = state == WR_AW && !w_done;
  assign awaddr = addr_q;
  assign awid = id_q;
  assign awlen = 8'd0;
  assign awsize = {1'b0, size_q};
  assign awburst = AXI_BURST_INCR;
  assign wlast = 1'b1;
  assign bready = state == WR_B;
  assign rd_fin = state == RD_D && rvalid;
  assign wr_fin = state == WR_B && bvalid;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = req_valid ? (req_wr ? WR_AW : RD_A) : IDLE;
      RD_A:    state_nxt = arready ? RD_D : RD_A;
      RD_D:    state_nxt = rvalid ? IDLE : RD_D;
      WR_AW:   state_nxt = (aw_done || awready) && (w_done || wready) ? WR_B : WR_AW;
      WR_B:    state_nxt = bvalid ? IDLE : WR_B;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      size_q <= '0;
      id_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nxt;
      rsp_valid <= rd_fin || wr_fin;
      rsp_err <= rd_fin ? r_err : wr_fin && b_err;
      if (req_ready && req_valid) begin
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        size_q <= req_size;
        id_q <= req_id;
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready) w_done <= 1'b1;
      if (rd_fin) rsp_rdata <= rd_aligned;
      if (rd_fin || wr_fin) rsp_id <= id_q;
    end
  end
endmodule

// File: tb/tb_axi_master_bridge.sv
// tb_axi_master_bridge: scoreboard bench with a configurable-latency AXI slave model
module tb_axi_master_bridge;
`ifdef AXI_BRIDGE_RESP_CHECK_EN
  localparam bit RESP_EN = 1'b1;
`else
  localparam bit RESP_EN = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  logic req_valid, req_wr, req_ready, rsp_valid, rsp_err;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, rsp_rdata;
  logic [1:0] req_size;
  logic [3:0] req_id, rsp_id;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready, arvalid, arready, rvalid, rready, rlast;
  logic [31:0] awaddr, araddr;
  logic [3:0] awid, bid, arid, rid;
  logic [7:0] awlen, arlen, wstrb;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [63:0] wdata, rdata;

  axi_master_bridge dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_id(req_id), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  typedef struct {
    logic [3:0]  id;
    logic [63:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t sb[$];
  int checks = 0, passes = 0, rsp_cnt = 0, cyc = 0, last_rsp_cyc = 0;
  logic [63:0] last_rd = '0;
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [63:0] rdata_cfg = '0;
  logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;
  int ar_txn = 0, aw_txn = 0, aw_hi = 0, w_hi = 0;
  logic [31:0] cap_araddr, cap_awaddr;
  logic [2:0] cap_arsize, cap_awsize;
  logic [7:0] cap_arlen, cap_wstrb;
  logic [1:0] cap_arburst;
  logic [3:0] cap_arid;
  logic [63:0] cap_wdata;
  logic cap_wlast;

  always @(posedge clock) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // slave: drives at negedge, predicts handshakes for the following posedge
  initial begin
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, aw_got, w_got, b_pend;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    {ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, aw_got, w_got, b_pend} = '0;
    {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} = '0;
    {arready, rvalid, awready, wready, bvalid} = '0;
    rdata = '0; rresp = '0; rlast = 1'b1; rid = '0; bresp = '0; bid = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        {ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, aw_got, w_got, b_pend} = '0;
        {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} = '0;
        {arready, rvalid, awready, wready, bvalid} = '0;
      end else begin
        if (ar_hs) begin r_pend = 1; r_cnt = 0; end
        if (r_hs) r_pend = 0;
        if (aw_hs) aw_got = 1;
        if (w_hs) w_got = 1;
        if (b_hs) b_pend = 0;
        if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
        arready = arvalid && ar_cnt >= ar_dly;
        ar_cnt = arvalid ? ar_cnt + 1 : 0;
        awready = awvalid && aw_cnt >= aw_dly;
        aw_cnt = awvalid ? aw_cnt + 1 : 0;
        wready = wvalid && w_cnt >= w_dly;
        w_cnt = wvalid ? w_cnt + 1 : 0;
        rvalid = r_pend && r_cnt >= r_dly;
        if (r_pend) r_cnt++;
        rdata = rdata_cfg; rresp = rresp_cfg; rid = cap_arid;
        bvalid = b_pend && b_cnt >= b_dly;
        if (b_pend) b_cnt++;
        bresp = bresp_cfg; bid = cap_arid;
        if (awvalid) aw_hi++;
        if (wvalid) w_hi++;
        ar_hs = arvalid && arready;
        r_hs = rvalid && rready;
        aw_hs = awvalid && awready;
        w_hs = wvalid && wready;
        b_hs = bvalid && bready;
        if (ar_hs) begin
          ar_txn++; cap_araddr = araddr; cap_arsize = arsize; cap_arlen = arlen;
          cap_arburst = arburst; cap_arid = arid;
        end
        if (aw_hs) begin aw_txn++; cap_awaddr = awaddr; cap_awsize = awsize; end
        if (w_hs) begin cap_wdata = wdata; cap_wstrb = wstrb; cap_wlast = wlast; end
      end
    end
  end

  // scoreboard consumer: every completion pulse is matched against the oldest expectation
  initial begin
    rsp_t e;
    forever begin
      @(negedge clock);
      if (!reset && rsp_valid) begin
        rsp_cnt++;
        last_rsp_cyc = cyc;
        checks++;
        if (sb.size() == 0) $display("FAIL sb_unexpected: got rsp_valid id=%h, required no response", rsp_id);
        else begin
          passes++;
          e = sb.pop_front();
          checks++;
          if (rsp_id !== e.id) $display("FAIL rsp_id: got %h required %h", rsp_id, e.id);
          else passes++;
          checks++;
          if (rsp_rdata !== e.rdata) $display("FAIL rsp_rdata: got %h required %h", rsp_rdata, e.rdata);
          else passes++;
          checks++;
          if (rsp_err !== e.err) $display("FAIL rsp_err: got %b required %b", rsp_err, e.err);
          else passes++;
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] a, input logic [63:0] d, input logic [1:0] s,
                       input logic [3:0] id, input logic [63:0] exp_rd, input logic exp_err, output int acc);
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clock);
    checks++;
    if (!req_ready) $display("FAIL issue_ready: got req_ready=%b required 1", req_ready);
    else passes++;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_size = s; req_id = id;
    acc = cyc;
    sb.push_back('{id, exp_rd, exp_err});
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int c0, output bit ok);
    for (int i = 0; i < 100 && rsp_cnt == c0; i++) @(negedge clock);
    ok = rsp_cnt != c0;
  endtask

  task automatic test_reset;
    checks++;
    if ({req_ready, arvalid, awvalid, wvalid, rready, bready, rsp_valid, rsp_err} !== 8'b0)
      $display("FAIL reset_ctl: got %b required 00000000",
               {req_ready, arvalid, awvalid, wvalid, rready, bready, rsp_valid, rsp_err});
    else passes++;
    checks++;
    if (rsp_id !== 4'h0) $display("FAIL reset_id: got %h required 0", rsp_id);
    else passes++;
    checks++;
    if (rsp_rdata !== 64'h0) $display("FAIL reset_rdata: got %h required 0", rsp_rdata);
    else passes++;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", req_ready);
    else passes++;
  endtask

  task automatic test_read_d;
    int acc, c0;
    bit ok;
    ar_dly = 0; r_dly = 0; rdata_cfg = 64'h1122334455667788;
    c0 = rsp_cnt;
    issue(1'b0, 32'h8000_0000, 64'h0, 2'b11, 4'h1, 64'h1122334455667788, 1'b0, acc);
    wait_rsp(c0, ok);
    last_rd = 64'h1122334455667788;
    checks++;
    if (!ok) $display("FAIL read_d_timeout: got no rsp_valid required one");
    else passes++;
    checks++;
    if (last_rsp_cyc - acc !== 3) $display("FAIL read_d_latency: got %0d required 3", last_rsp_cyc - acc);
    else passes++;
    checks++;
    if ({cap_araddr, cap_arsize, cap_arlen, cap_arburst, cap_arid} !== {32'h8000_0000, 3'd3, 8'd0, 2'b01, 4'h1})
      $display("FAIL read_d_ar: got addr=%h size=%0d len=%0d burst=%b id=%h required 80000000/3/0/01/1",
               cap_araddr, cap_arsize, cap_arlen, cap_arburst, cap_arid);
    else passes++;
  endtask

  task automatic test_read_b;
    int acc, c0;
    bit ok;
    ar_dly = 2; r_dly = 1; rdata_cfg = 64'h1122334455667788;
    c0 = rsp_cnt;
    issue(1'b0, 32'h8000_0003, 64'h0, 2'b00, 4'h3, 64'h55, 1'b0, acc);
    wait_rsp(c0, ok);
    last_rd = 64'h55;
    checks++;
    if (!ok) $display("FAIL read_b_timeout: got no rsp_valid required one");
    else passes++;
    checks++;
    if (last_rsp_cyc - acc !== 6) $display("FAIL read_b_latency: got %0d required 6", last_rsp_cyc - acc);
    else passes++;
    checks++;
    if ({cap_araddr, cap_arsize} !== {32'h8000_0003, 3'd0})
      $display("FAIL read_b_ar: got addr=%h size=%0d required 80000003/0", cap_araddr, cap_arsize);
    else passes++;
    ar_dly = 0; r_dly = 0;
  endtask

  task automatic test_write_h;
    int acc, c0, aw0;
    bit ok;
    aw_dly = 3; w_dly = 0; b_dly = 1; bresp_cfg = 2'b00;
    aw_hi = 0; w_hi = 0; aw0 = aw_txn; c0 = rsp_cnt;
    issue(1'b1, 32'h8000_0006, 64'hBEEF, 2'b01, 4'h3, last_rd, 1'b0, acc);
    wait_rsp(c0, ok);
    repeat (5) @(negedge clock);
    checks++;
    if (!ok || rsp_cnt - c0 !== 1) $display("FAIL write_h_rsp_count: got %0d required 1", rsp_cnt - c0);
    else passes++;
    checks++;
    if (cap_wstrb !== 8'hC0) $display("FAIL write_h_wstrb: got %h required c0", cap_wstrb);
    else passes++;
    checks++;
    if (cap_wdata !== 64'hBEEF_0000_0000_0000 || cap_wlast !== 1'b1)
      $display("FAIL write_h_wdata: got %h last=%b required beef000000000000 last=1", cap_wdata, cap_wlast);
    else passes++;
    checks++;
    if ({aw_hi, w_hi} !== {32'd4, 32'd1}) $display("FAIL write_h_valid_cycles: got aw=%0d w=%0d required aw=4 w=1", aw_hi, w_hi);
    else passes++;
    checks++;
    if ({cap_awaddr, cap_awsize, aw_txn - aw0} !== {32'h8000_0006, 3'd1, 32'd1})
      $display("FAIL write_h_aw: got addr=%h size=%0d txns=%0d required 80000006/1/1", cap_awaddr, cap_awsize, aw_txn - aw0);
    else passes++;
    aw_dly = 0; b_dly = 0;
  endtask

  task automatic test_write_lanes;
    logic [31:0] a[2] = '{32'h8000_0004, 32'h8000_0000};
    logic [63:0] d[2] = '{64'hDEADBEEF, 64'h0123_4567_89AB_CDEF};
    logic [1:0]  s[2] = '{2'b10, 2'b11};
    logic [7:0]  es[2] = '{8'hF0, 8'hFF};
    logic [63:0] ed[2] = '{64'hDEAD_BEEF_0000_0000, 64'h0123_4567_89AB_CDEF};
    int acc, c0;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      w_dly = k == 0 ? 2 : 0;
      c0 = rsp_cnt;
      issue(1'b1, a[k], d[k], s[k], 4'h1, last_rd, 1'b0, acc);
      wait_rsp(c0, ok);
      checks++;
      if (!ok || cap_wstrb !== es[k] || cap_wdata !== ed[k])
        $display("FAIL write_lanes%0d: got ok=%b strb=%h data=%h required strb=%h data=%h",
                 k, ok, cap_wstrb, cap_wdata, es[k], ed[k]);
      else passes++;
    end
    w_dly = 0;
  endtask

  task automatic test_held_valid;
    int acc, c0, ar0, aw0;
    ar_dly = 1; r_dly = 1; rdata_cfg = 64'hA5A5_0000_1234_5678;
    acc = 0; c0 = rsp_cnt; ar0 = ar_txn; aw0 = aw_txn;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h8000_0000; req_size = 2'b11; req_id = 4'h1;
    for (int i = 0; i < 30; i++) begin
      if (req_ready) begin
        acc++;
        sb.push_back('{4'h1, 64'hA5A5_0000_1234_5678, 1'b0});
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0)
          $display("FAIL held_ready_busy: got %b required 00000", {arvalid, rready, awvalid, wvalid, bready});
        else passes++;
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 50 && rsp_cnt - c0 < acc; i++) @(negedge clock);
    last_rd = 64'hA5A5_0000_1234_5678;
    checks++;
    if (acc !== 6) $display("FAIL held_accepts: got %0d required 6", acc);
    else passes++;
    checks++;
    if ({rsp_cnt - c0, ar_txn - ar0, aw_txn - aw0} !== {acc, acc, 32'd0})
      $display("FAIL held_txn_count: got rsp=%0d ar=%0d aw=%0d required %0d/%0d/0",
               rsp_cnt - c0, ar_txn - ar0, aw_txn - aw0, acc, acc);
    else passes++;
    ar_dly = 0; r_dly = 0;
  endtask

  task automatic test_reset_mid;
    int acc, c0;
    bit ok;
    r_dly = 20; rdata_cfg = 64'h1122334455667788;
    issue(1'b0, 32'h8000_0000, 64'h0, 2'b11, 4'h3, 64'h1122334455667788, 1'b0, acc);
    for (int i = 0; i < 20 && !rready; i++) @(negedge clock);
    checks++;
    if (rready !== 1'b1) $display("FAIL reset_mid_rd_d: got rready=%b required 1", rready);
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({arvalid, rready, rsp_valid, req_ready} !== 4'b0)
      $display("FAIL reset_mid_async: got %b required 0000", {arvalid, rready, rsp_valid, req_ready});
    else passes++;
    sb.delete();
    last_rd = '0;
    r_dly = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata} !== {1'b1, 1'b0, 64'h0})
      $display("FAIL reset_mid_release: got ready=%b valid=%b rdata=%h required 1/0/0", req_ready, rsp_valid, rsp_rdata);
    else passes++;
    c0 = rsp_cnt;
    issue(1'b0, 32'h8000_0002, 64'h0, 2'b01, 4'h1, 64'h5566, 1'b0, acc);
    wait_rsp(c0, ok);
    last_rd = 64'h5566;
    checks++;
    if (!ok || last_rsp_cyc - acc !== 3) $display("FAIL reset_mid_recover: got ok=%b latency=%0d required 1/3", ok, last_rsp_cyc - acc);
    else passes++;
  endtask

  task automatic test_resp_err;
    int acc, c0;
    bit ok;
    bresp_cfg = 2'b10;
    c0 = rsp_cnt;
    issue(1'b1, 32'h8000_0010, 64'h77, 2'b00, 4'h3, last_rd, RESP_EN, acc);
    wait_rsp(c0, ok);
    checks++;
    if (!ok) $display("FAIL resp_err_write: got no rsp_valid required one");
    else passes++;
    bresp_cfg = 2'b00; rresp_cfg = 2'b11; rdata_cfg = 64'hFFEE_DDCC_BBAA_9988;
    c0 = rsp_cnt;
    issue(1'b0, 32'h8000_0004, 64'h0, 2'b10, 4'h1, 64'hFFEE_DDCC, RESP_EN, acc);
    wait_rsp(c0, ok);
    last_rd = 64'hFFEE_DDCC;
    rresp_cfg = 2'b00;
    c0 = rsp_cnt;
    issue(1'b0, 32'h8000_0001, 64'h0, 2'b00, 4'h3, 64'h99, 1'b0, acc);
    wait_rsp(c0, ok);
    last_rd = 64'h99;
    checks++;
    if (!ok || rsp_cnt - c0 !== 1) $display("FAIL resp_err_clear: got %0d responses required 1", rsp_cnt - c0);
    else passes++;
  endtask

  initial begin
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0; req_id = '0;
    repeat (3) @(negedge clock);
    test_reset;
    test_read_d;
    test_read_b;
    test_write_h;
    test_write_lanes;
    test_held_valid;
    test_reset_mid;
    test_resp_err;
    repeat (5) @(negedge clock);
    checks++;
    if (sb.size() !== 0) $display("FAIL sb_drain: got %0d pending required 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
